// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control bus between the multicycle MIPS controller and its datapath
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [2:0] alu_ctrl;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_ctrl, illegal, state_o
  );

  modport slave (
    output op, funct, zero,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_ctrl, illegal, state_o
  );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS main controller FSM; MC_ILLEGAL_TRAP_EN adds the ERROR trap state
module mc_ctrl #(
  parameter int FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.master  bus
);

  localparam logic [3:0] FW4 = 4'(FETCH_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
    ,S_ERROR = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       pc_write;
    logic       branch;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctl_t;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t S_BAD = S_ERROR;
`else
  localparam state_t S_BAD = S_FETCH;
`endif

  state_t     state, nxt;
  logic [3:0] cnt, nxt_cnt;
  logic [2:0] rtype_alu;
  logic       rtype_ok;
  ctl_t       ctl, ctl_nxt;

  // Control word for a given state; outputs are registered from the next state so they stay Moore.
  function automatic ctl_t decode(state_t s, logic [3:0] c, logic [2:0] ralu);
    ctl_t d;
    d = '0;
    d.alu_ctrl = 3'b010;
    case (s)
      S_FETCH: begin
        d.alu_src_b = 2'b01;
        d.ir_write  = (c == FW4);
        d.pc_write  = (c == FW4);
      end
      S_DECODE: d.alu_src_b = 2'b11;
      S_MEMADR: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      S_MEMRD:  d.iord = 1'b1;
      S_MEMWB:  begin d.mem_to_reg = 1'b1; d.reg_write = 1'b1; end
      S_MEMWR:  begin d.iord = 1'b1; d.mem_write = 1'b1; end
      S_RTYPE:  begin d.alu_src_a = 1'b1; d.alu_ctrl = ralu; end
      S_ALUWB:  begin d.reg_dst = 1'b1; d.reg_write = 1'b1; end
      S_BRANCH: begin
        d.alu_src_a = 1'b1;
        d.alu_ctrl  = 3'b100;
        d.pc_src    = 2'b01;
        d.branch    = 1'b1;
      end
      S_ADDIEX: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      S_ADDIWB: d.reg_write = 1'b1;
      S_JUMP:   begin d.pc_src = 2'b10; d.pc_write = 1'b1; end
`ifdef MC_ILLEGAL_TRAP_EN
      S_ERROR:  d.illegal = 1'b1;
`endif
      default:  d = d;
    endcase
    return d;
  endfunction

  always_comb begin
    rtype_ok  = 1'b1;
    rtype_alu = 3'b010;
    case (bus.funct)
      6'b100100: rtype_alu = 3'b000;
      6'b100101: rtype_alu = 3'b001;
      6'b100000: rtype_alu = 3'b010;
      6'b100010: rtype_alu = 3'b011;
      6'b100111: rtype_alu = 3'b101;
      default:   rtype_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    case (state)
      S_FETCH: begin
        if (cnt == FW4) begin
          nxt     = S_DECODE;
          nxt_cnt = 4'd0;
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_BAD;
        endcase
      end
      S_MEMADR: nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_RTYPE:  nxt = rtype_ok ? S_ALUWB : S_BAD;
      S_ADDIEX: nxt = S_ADDIWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ERROR:  nxt = S_ERROR;
`endif
      default:  nxt = S_FETCH;
    endcase
    ctl_nxt = decode(nxt, nxt_cnt, rtype_alu);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= 4'd0;
      ctl   <= decode(S_FETCH, 4'd0, 3'b010);
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      ctl   <= ctl_nxt;
    end
  end

  // Strobes are masked while reset is high so an aborted instruction writes nothing.
  assign bus.iord       = ctl.iord;
  assign bus.mem_write  = ctl.mem_write & ~reset;
  assign bus.ir_write   = ctl.ir_write & ~reset;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.reg_write  = ctl.reg_write & ~reset;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.alu_ctrl   = ctl.alu_ctrl;
  assign bus.pc_en      = (ctl.pc_write | (ctl.branch & bus.zero)) & ~reset;
  assign bus.state_o    = state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal    = ctl.illegal;
`else
  assign bus.illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized instruction-level bench for mc_ctrl against a state-sequence model
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  int         fw;
  int         checks = 0;
  int         errors = 0;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mc_ctrl_if bus0 ();
  mc_ctrl_if bus3 ();

  assign bus0.op = op;
  assign bus0.funct = funct;
  assign bus0.zero = zero;
  assign bus3.op = op;
  assign bus3.funct = funct;
  assign bus3.zero = zero;

  mc_ctrl #(.FETCH_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mc_ctrl #(.FETCH_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (fw=%0d t=%0t)", tag, got, exp, fw, $time);
    end
  endtask

  task automatic sample(output logic [3:0] st, output logic [4:0] stb, output logic [10:0] sel);
    if (fw == 3) begin
      st  = bus3.state_o;
      stb = {bus3.mem_write, bus3.ir_write, bus3.reg_write, bus3.pc_en, bus3.illegal};
      sel = {bus3.iord, bus3.reg_dst, bus3.mem_to_reg, bus3.alu_src_a,
             bus3.alu_src_b, bus3.pc_src, bus3.alu_ctrl};
    end else begin
      st  = bus0.state_o;
      stb = {bus0.mem_write, bus0.ir_write, bus0.reg_write, bus0.pc_en, bus0.illegal};
      sel = {bus0.iord, bus0.reg_dst, bus0.mem_to_reg, bus0.alu_src_a,
             bus0.alu_src_b, bus0.pc_src, bus0.alu_ctrl};
    end
  endtask

  function automatic logic [3:0] funct_alu(logic [5:0] f, output bit ok);
    ok = 1'b1;
    case (f)
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100000: return 3'b010;
      6'b100010: return 3'b011;
      6'b100111: return 3'b101;
      default: begin ok = 1'b0; return 3'b010; end
    endcase
  endfunction

  // Documented select values per state; mask bits mark the fields the state defines.
  // Field order: iord reg_dst mem_to_reg alu_src_a alu_src_b pc_src alu_ctrl
  task automatic exp_sel(int s, logic [5:0] f, output logic [10:0] v, output logic [10:0] m);
    bit ok;
    logic [3:0] a;
    a = funct_alu(f, ok);
    case (s)
      0:  begin v = 11'b0_0_0_0_01_00_010; m = 11'b1_0_0_1_11_11_111; end
      1:  begin v = 11'b0_0_0_0_11_00_010; m = 11'b0_0_0_1_11_00_111; end
      2:  begin v = 11'b0_0_0_1_10_00_010; m = 11'b0_0_0_1_11_00_111; end
      3:  begin v = 11'b1_0_0_0_00_00_000; m = 11'b1_0_0_0_00_00_000; end
      4:  begin v = 11'b0_0_1_0_00_00_000; m = 11'b0_1_1_0_00_00_000; end
      5:  begin v = 11'b1_0_0_0_00_00_000; m = 11'b1_0_0_0_00_00_000; end
      6:  begin v = {8'b0_0_0_1_00_00, a[2:0]}; m = 11'b0_0_0_1_11_00_111; end
      7:  begin v = 11'b0_1_0_0_00_00_000; m = 11'b0_1_1_0_00_00_000; end
      8:  begin v = 11'b0_0_0_1_00_01_100; m = 11'b0_0_0_1_11_11_111; end
      9:  begin v = 11'b0_0_0_1_10_00_010; m = 11'b0_0_0_1_11_00_111; end
      10: begin v = 11'b0_0_0_0_00_00_000; m = 11'b0_1_1_0_00_00_000; end
      11: begin v = 11'b0_0_0_0_00_10_000; m = 11'b0_0_0_0_00_11_000; end
      default: begin v = '0; m = '0; end
    endcase
  endtask

  task automatic do_reset();
    logic [3:0]  st;
    logic [4:0]  stb;
    logic [10:0] sel, v, m;
    reset = 1'b1;
    @(negedge clk);
    #1;
    sample(st, stb, sel);
    exp_sel(0, funct, v, m);
    check_eq("reset state", 32'(st), 32'd0);
    check_eq("reset strobes", 32'(stb), 32'd0);
    check_eq("reset selects", 32'(sel & m), 32'(v & m));
    reset = 1'b0;
  endtask

  // zmode: -1 random zero each cycle, else held at that value; abort_at: cycle index to reset after.
  task automatic run_instr(logic [5:0] o, logic [5:0] f, int zmode, int abort_at);
    int          seq[$];
    bit          ok;
    logic [3:0]  st, a;
    logic [4:0]  stb, estb;
    logic [10:0] sel, v, m;
    int          s;
    op = o;
    funct = f;
    a = funct_alu(f, ok);
    for (int i = 0; i <= fw; i++) seq.push_back(0);
    seq.push_back(1);
    case (o)
      6'b100011: seq = {seq, 2, 3, 4};
      6'b101011: seq = {seq, 2, 5};
      6'b000000: begin
        seq.push_back(6);
        if (ok) seq.push_back(7);
        else if (TRAP) seq = {seq, 12, 12, 12};
      end
      6'b000100: seq.push_back(8);
      6'b001000: seq = {seq, 9, 10};
      6'b000010: seq.push_back(11);
      default:   if (TRAP) seq = {seq, 12, 12, 12};
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      s = seq[i];
      sample(st, stb, sel);
      estb = {s == 5, s == 0 && i == fw, s == 4 || s == 7 || s == 10,
              (s == 0 && i == fw) || s == 11 || (s == 8 && zero), s == 12};
      exp_sel(s, f, v, m);
      check_eq($sformatf("state op=%0h c%0d", o, i), 32'(st), 32'(s));
      check_eq($sformatf("strobes op=%0h c%0d", o, i), 32'(stb), 32'(estb));
      check_eq($sformatf("selects op=%0h c%0d", o, i), 32'(sel & m), 32'(v & m));
      if (i == abort_at) begin
        do_reset();
        return;
      end
      @(negedge clk);
    end
    if (seq[seq.size()-1] == 12) do_reset();
  endtask

  task automatic random_instrs(int n);
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] o, f;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b100111, 6'b000000};
    for (int k = 0; k < n; k++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 6'b111111) o = 6'($urandom_range(0, 63));
      f = fns[$urandom_range(0, 5)];
      if (f == 6'b000000) f = 6'($urandom_range(0, 63));
      run_instr(o, f, -1, -1);
    end
  endtask

  initial begin
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    reset = 1'b1;
    fw = 0;
    do_reset();
    run_instr(6'b000000, 6'b100010, -1, -1);
    run_instr(6'b100011, 6'b000000, -1, -1);
    run_instr(6'b101011, 6'b000000, -1, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b001000, 6'b000000, -1, -1);
    run_instr(6'b000010, 6'b000000, -1, -1);
    run_instr(6'b000000, 6'b111000, -1, -1);
    run_instr(6'b111111, 6'b000000, -1, -1);
    run_instr(6'b100011, 6'b000000, -1, 4);
    random_instrs(40);

    fw = 3;
    do_reset();
    run_instr(6'b000000, 6'b100100, -1, -1);
    run_instr(6'b100011, 6'b000000, -1, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    random_instrs(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle MIPS main controller. Moore FSM that sequences the shared ALU, register file, memory and PC.
- It is the only block that drives alu_ctrl. It issues one microstep per clock: FETCH, DECODE, execute, memory access, writeback.
- Decodes op/funct from the instruction register. Generates all datapath enables and mux selects, plus the PC enable from the ALU zero flag.

Parameters:
- FETCH_WAIT, 0: extra wait cycles spent in FETCH before the instruction is captured (slow memory). Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag (1 when operands are equal in BEQ mode)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register select: 0=rt, 1=rd
- mem_to_reg  output  1  writeback data select: 0=ALUOut, 1=Data
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0=PC, 1=A reg
- alu_src_b  output  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- pc_src  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- pc_en  output  1  PC load = pc_write | (branch & zero)
- alu_ctrl  output  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 BEQ-compare, 101 NOR
- illegal  output  1  illegal instruction flag (feature only; tied 0 otherwise)
- state_o  output  4  current state encoding, for debug

Behaviour:
- Reset: synchronous. State goes to FETCH and the wait counter to 0. Every write/enable output is 0; selects take their FETCH values.
- All outputs decode from state only (Moore), except pc_en, which also uses zero.
- FETCH (0): iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00.
  - While the wait counter is below FETCH_WAIT: counter increments; ir_write=0 and pc_write=0.
  - When the counter equals FETCH_WAIT: ir_write=1, pc_write=1, counter clears, next state DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut). Next state by op:
  - 100011 (LW) or 101011 (SW) -> MEMADR
  - 000000 -> RTYPE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else -> FETCH (feature off) or ERROR (feature on)
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_ctrl=010. Next: MEMRD if LW, MEMWR if SW.
- MEMRD (3): iord=1 -> MEMWB.
- MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR (5): iord=1, mem_write=1 -> FETCH.
- RTYPE (6): alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
  - 100100 -> 000 (AND)
  - 100101 -> 001 (OR)
  - 100000 -> 010 (ADD)
  - 100010 -> 011 (SUB)
  - 100111 -> 101 (NOR)
  - Unlisted funct -> illegal. Feature off: alu_ctrl=010 and RTYPE goes straight to FETCH, skipping writeback. Feature on: go to ERROR.
- Legal RTYPE -> ALUWB (7): reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_ctrl=100, pc_src=01, branch=1. pc_en=zero -> FETCH.
- ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_ctrl=010 -> ADDIWB.
- ADDIWB (10): reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP (11): pc_src=10, pc_write=1 -> FETCH.
- Latencies (FETCH_WAIT=0): R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3 cycles.
- The wait counter is 4 bits wide and is never advanced outside FETCH.
- Reset asserted mid-instruction aborts it. The cycle with reset high produces no write strobes.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: unknown op or unlisted R-type funct enters ERROR (12). ERROR holds all enables at 0 and sets illegal=1. The FSM stays there until reset.
- Undefined: ERROR is not built; illegal is tied to 0; unknown encodings return to FETCH as a NOP.

Test Plan:
- R-type: reset, op=000000, funct=100010 -> states 0,1,6,7,0; alu_ctrl=011 in RTYPE; reg_write=1 and reg_dst=1 only in ALUWB.
- LW then SW: op=100011 -> states 0,1,2,3,4; iord=1 in MEMRD; mem_to_reg=1 and reg_write=1 in MEMWB. op=101011 -> mem_write=1 for exactly one cycle.
- BEQ: op=000100. With zero=1: pc_en=1 and pc_src=01 in BRANCH, alu_ctrl=100. With zero=0: pc_en=0.
- FETCH_WAIT=3: ir_write and pc_en both 0 for 3 cycles, then both 1 for one cycle, then DECODE.
- Illegal op=111111. Feature off: returns to FETCH with no reg_write/mem_write. Feature on: state_o=12, illegal=1, sticky until reset.
- Reset asserted in MEMWB -> next cycle state_o=0, reg_write=0, all enables 0.
